// File: rtl/mips_pkg.sv
// Definitions shared between the MIPS core and its instruction-side loader.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } ldr_state_t;

endpackage

// File: rtl/instr_mem_loader_instr_store.sv
// DEPTH x 32 instruction array: one synchronous write port, asynchronous read.
module instr_store
  import mips_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // No reset: contents survive reset and load_clear by design.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// Packs a big-endian byte stream into the instruction store and gates the core.
// Handshake: a byte transfers on a rising edge where load_valid && load_ready;
// load_last and load_byte are only meaningful while load_valid is high.
module instr_mem_loader
  import mips_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [7:0]         load_byte,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               load_clear,
  input  logic [31:0]        PC,
  output logic [INSTR_W-1:0] Instr,
  output logic               core_run,
  output logic [ADDR_W:0]    prog_len,
  output logic               overflow,
  output ldr_state_t         state_dbg
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  ldr_state_t         state, state_nxt;
  logic [1:0]         byte_cnt;
  logic [23:0]        asm_q;
  logic [ADDR_W:0]    wr_ptr;
  logic               ovf_q;
  logic               accept;
  logic               full;
  logic               mem_we;
  logic [INSTR_W-1:0] mem_wdata;
  logic [INSTR_W-1:0] mem_rdata;
  logic               pc_in_prog;

  assign load_ready = (state != RUN);
  assign core_run   = (state == RUN);
  assign accept     = load_valid && load_ready;
  assign full       = (wr_ptr == FULL_CNT);
  assign prog_len   = wr_ptr;
  assign overflow   = ovf_q;
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_wdata = NOP_INSTR;
    case (state)
      IDLE, LOAD: begin
        if (accept) begin
          state_nxt = load_last ? RUN : LOAD;
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (load_clear) begin
      state_nxt = IDLE;
    end

    // A word is committed when complete, or early (zero-padded) on load_last.
    if (accept && !load_clear && !full && (byte_cnt == 2'd3 || load_last)) begin
      mem_we = 1'b1;
    end
    case (byte_cnt)
      2'd0:    mem_wdata = {load_byte, 24'h0};
      2'd1:    mem_wdata = {asm_q[7:0], load_byte, 16'h0};
      2'd2:    mem_wdata = {asm_q[15:0], load_byte, 8'h0};
      default: mem_wdata = {asm_q, load_byte};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt <= 2'd0;
      asm_q    <= 24'h0;
      wr_ptr   <= '0;
      ovf_q    <= 1'b0;
    end else if (load_clear) begin
      byte_cnt <= 2'd0;
      asm_q    <= 24'h0;
      wr_ptr   <= '0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      if (full) begin
        ovf_q <= 1'b1;
      end else begin
        asm_q    <= {asm_q[15:0], load_byte};
        byte_cnt <= load_last ? 2'd0 : byte_cnt + 2'd1;
        if (mem_we) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

  instr_store #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (mem_wdata),
    .raddr (PC[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  // Full-width compare so any set upper PC bit reads as out of range.
  assign pc_in_prog = (PC < {{(32-ADDR_W-1){1'b0}}, wr_ptr});
  assign Instr      = (state == RUN && pc_in_prog) ? mem_rdata : NOP_INSTR;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader with a byte-list reference model.
module tb_instr_mem_loader;
  import mips_pkg::*;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  localparam int K_INSTR = 0;
  localparam int K_LEN   = 1;
  localparam int K_RUN   = 2;
  localparam int K_OVF   = 3;
  localparam int K_RDY   = 4;
  localparam int K_STATE = 5;

  logic              clk;
  logic              reset;
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_last;
  logic              load_ready;
  logic              load_clear;
  logic [31:0]       PC;
  logic [31:0]       Instr;
  logic              core_run;
  logic [ADDR_W:0]   prog_len;
  logic              overflow;
  ldr_state_t        state_dbg;

  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_clear (load_clear),
    .PC         (PC),
    .Instr      (Instr),
    .core_run   (core_run),
    .prog_len   (prog_len),
    .overflow   (overflow),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [31:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        probe  = 1'b0;

  logic [31:0] mon_got;
  logic [31:0] mon_exp;
  int          mon_kind;
  string       mon_name;

  always @(negedge clk) begin
    if (probe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_probe: got probe with empty queue, required queued entry");
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_kind = kind_q.pop_front();
        mon_name = name_q.pop_front();
        case (mon_kind)
          K_INSTR: mon_got = Instr;
          K_LEN:   mon_got = 32'(prog_len);
          K_RUN:   mon_got = {31'b0, core_run};
          K_OVF:   mon_got = {31'b0, overflow};
          K_RDY:   mon_got = {31'b0, load_ready};
          default: mon_got = 32'(state_dbg);
        endcase
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL %s: got %h required %h", mon_name, mon_got, mon_exp);
        end
      end
    end
  end

  // Reference model: the accepted bytes of the current program as a plain list.
  logic [7:0]  bytes_q[$];
  logic [31:0] m_mem [DEPTH];
  int          m_len;
  bit          m_ovf;

  function automatic void model_finish();
    int n;
    int kept;
    n     = bytes_q.size();
    kept  = (n > 4*DEPTH) ? 4*DEPTH : n;
    m_ovf = (n > 4*DEPTH);
    m_len = (kept + 3) / 4;
    for (int w = 0; w < m_len; w++) begin
      logic [31:0] word;
      word = 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (4*w + b < kept) begin
          word = word | (32'(bytes_q[4*w + b]) << (24 - 8*b));
        end
      end
      m_mem[w] = word;
    end
    bytes_q.delete();
  endfunction

  task automatic expect_val(input int kind, input logic [31:0] pc,
                            input logic [31:0] val, input string name);
    PC = pc;
    exp_q.push_back(val);
    kind_q.push_back(kind);
    name_q.push_back(name);
    probe = 1'b1;
    @(negedge clk);
    #1 probe = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input int gap_pct);
    bit rdy;
    while ($urandom_range(99) < gap_pct) begin
      load_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    rdy        = load_ready;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    if (rdy) begin
      bytes_q.push_back(b);
      if (last) model_finish();
    end
  endtask

  task automatic do_clear(input bit with_byte, input logic [7:0] b);
    load_clear = 1'b1;
    load_valid = with_byte;
    load_byte  = b;
    load_last  = 1'b0;
    @(posedge clk);
    #1;
    load_clear = 1'b0;
    load_valid = 1'b0;
    bytes_q.delete();
    m_len = 0;
    m_ovf = 1'b0;
  endtask

  task automatic check_prog();
    int lim;
    expect_val(K_RUN, 0, 1, "core_run_after_last");
    expect_val(K_RDY, 0, 0, "ready_low_in_run");
    expect_val(K_LEN, 0, 32'(m_len), "prog_len");
    expect_val(K_OVF, 0, {31'b0, m_ovf}, "overflow");
    lim = (m_len < 6) ? m_len : 6;
    for (int p = 0; p < lim; p++) expect_val(K_INSTR, p, m_mem[p], "instr_word");
    if (m_len > 0) expect_val(K_INSTR, m_len - 1, m_mem[m_len - 1], "instr_last_word");
    expect_val(K_INSTR, m_len, 32'h0, "instr_past_len");
    expect_val(K_INSTR, 32'h8000_0000, 32'h0, "instr_upper_pc_bits");
  endtask

  task automatic send_prog(input logic [7:0] bs[$], input int gap_pct);
    for (int i = 0; i < bs.size(); i++) send_byte(bs[i], i == bs.size() - 1, gap_pct);
  endtask

  initial begin
    logic [7:0] prog_a[$];
    logic [7:0] prog_b[$];
    logic [7:0] rnd[$];
    int         n;

    reset      = 1'b0;
    load_valid = 1'b0;
    load_byte  = 8'h0;
    load_last  = 1'b0;
    load_clear = 1'b0;
    PC         = 32'h0;
    m_len      = 0;
    m_ovf      = 1'b0;
    #23;
    expect_val(K_RUN, 0, 0, "reset_core_run");
    expect_val(K_RDY, 0, 1, "reset_load_ready");
    expect_val(K_LEN, 0, 0, "reset_prog_len");
    expect_val(K_OVF, 0, 0, "reset_overflow");
    expect_val(K_INSTR, 0, 0, "reset_instr");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Two-word program
    prog_a = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    for (int i = 0; i < 7; i++) send_byte(prog_a[i], 1'b0, 0);
    expect_val(K_RUN, 0, 0, "core_run_low_in_load");
    send_byte(prog_a[7], 1'b1, 0);
    expect_val(K_INSTR, 0, 32'h2008_0005, "prog_a_pc0");
    expect_val(K_INSTR, 1, 32'h2009_0007, "prog_a_pc1");
    expect_val(K_LEN, 0, 2, "prog_a_len");
    check_prog();

    // Bytes offered in RUN must be refused
    for (int i = 0; i < 3; i++) send_byte(8'hFF, 1'b0, 0);
    expect_val(K_LEN, 0, 2, "run_len_unchanged");
    expect_val(K_INSTR, 0, 32'h2008_0005, "run_pc0_unchanged");
    expect_val(K_INSTR, 1, 32'h2009_0007, "run_pc1_unchanged");

    // Clear with a coincident byte, which must be dropped
    do_clear(1'b1, 8'h55);
    expect_val(K_STATE, 0, 32'(IDLE), "clear_state_idle");
    expect_val(K_RUN, 0, 0, "clear_core_run");
    expect_val(K_LEN, 0, 0, "clear_prog_len");
    expect_val(K_OVF, 0, 0, "clear_overflow");
    expect_val(K_INSTR, 0, 0, "clear_instr_pc0");
    expect_val(K_RDY, 0, 1, "clear_ready");

    // Partial final word
    prog_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    send_prog(prog_b, 0);
    expect_val(K_INSTR, 0, 32'hAABB_CCDD, "prog_b_pc0");
    expect_val(K_INSTR, 1, 32'h1122_0000, "prog_b_pc1");
    expect_val(K_LEN, 0, 2, "prog_b_len");
    check_prog();

    // Single-byte program
    do_clear(1'b0, 8'h0);
    send_byte(8'h3C, 1'b1, 0);
    expect_val(K_INSTR, 0, 32'h3C00_0000, "single_byte_word");
    check_prog();

    // Overflow: DEPTH*4+3 bytes
    do_clear(1'b0, 8'h0);
    rnd.delete();
    for (int i = 0; i < 4*DEPTH + 3; i++) rnd.push_back(8'($urandom_range(255)));
    send_prog(rnd, 0);
    expect_val(K_LEN, 0, 64, "ovf_prog_len");
    expect_val(K_OVF, 0, 1, "ovf_flag");
    expect_val(K_INSTR, 63, {rnd[252], rnd[253], rnd[254], rnd[255]}, "ovf_pc63");
    expect_val(K_INSTR, 64, 0, "ovf_pc64");
    check_prog();
    do_clear(1'b0, 8'h0);
    expect_val(K_OVF, 0, 0, "ovf_cleared");

    // Random programs with bubbles
    for (int it = 0; it < 6; it++) begin
      do_clear(1'b0, 8'h0);
      rnd.delete();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) rnd.push_back(8'($urandom_range(255)));
      send_prog(rnd, 35);
      check_prog();
    end

    // Async reset mid-word
    do_clear(1'b0, 8'h0);
    send_byte(8'h12, 1'b0, 0);
    send_byte(8'h34, 1'b0, 0);
    expect_val(K_INSTR, 0, 0, "instr_zero_in_load");
    expect_val(K_RUN, 0, 0, "run_low_midword");
    @(posedge clk);
    #2 reset = 1'b0;
    expect_val(K_STATE, 0, 32'(IDLE), "async_reset_state");
    expect_val(K_RDY, 0, 1, "async_reset_ready");
    expect_val(K_LEN, 0, 0, "async_reset_len");
    expect_val(K_RUN, 0, 0, "async_reset_run");
    bytes_q.delete();
    m_len = 0;
    m_ovf = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    prog_a = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_prog(prog_a, 0);
    expect_val(K_INSTR, 0, 32'hDEAD_BEEF, "post_reset_pc0");
    check_prog();

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Instruction-side counterpart of the multicycle MIPS core. The core drives PC and consumes Instr combinationally.
- This block receives a program as a byte stream over a valid/ready handshake and packs it into a word-addressed instruction store.
- It answers the core's PC with Instr, and holds the core idle through core_run until a complete program is present.

Parameters:
- DEPTH, 64, number of 32-bit instruction words stored.
- ADDR_W, 6, word-address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_valid  input  1  byte-stream valid.
- load_byte  input  8  program byte, big-endian within a word (first byte → Instr[31:24]).
- load_last  input  1  qualifies the final byte of the program; meaningful only with load_valid.
- load_ready  output  1  block accepts a byte this cycle.
- load_clear  input  1  synchronous request to discard the program and return to IDLE.
- PC  input  32  word address from the core. The core increments PC by 1 per instruction.
- Instr  output  32  instruction at PC, combinational from PC.
- core_run  output  1  program loaded; the core may execute.
- prog_len  output  ADDR_W+1  number of words stored (0..DEPTH).
- overflow  output  1  sticky: bytes arrived after the store was full.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; byte_cnt=0; wr_ptr=0; prog_len=0.
  - overflow=0; core_run=0; load_ready=1; Instr=0.
  - Memory contents are not cleared.
- A byte is accepted on a rising clk edge where load_valid && load_ready.
- States:
  - IDLE: load_ready=1, core_run=0. An accepted byte moves to LOAD and is processed as a LOAD byte in the same cycle.
  - LOAD: load_ready=1, core_run=0.
    - Each accepted byte shifts into a 24-bit assembly register; byte_cnt increments mod 4.
    - On the 4th byte, {assembly, byte} is written to mem[wr_ptr]; wr_ptr increments.
    - An accepted byte with load_last=1 moves to RUN next cycle.
    - If load_last lands on a partial word (byte_cnt≠3), the word is written zero-padded in its low bytes and still counts in prog_len.
  - RUN: load_ready=0, core_run=1. Bytes are not accepted. This state is held until load_clear or reset.
- prog_len equals wr_ptr, updated with each word write. Its final value is visible the cycle core_run rises.
- Full condition (wr_ptr==DEPTH):
  - Further accepted bytes are discarded and set overflow=1 (sticky until reset or load_clear).
  - load_ready stays 1 so the stream drains.
  - load_last still moves the block to RUN.
- Read path:
  - Instr = mem[PC[ADDR_W-1:0]] when state==RUN && PC < prog_len.
  - Otherwise Instr = 32'h0000_0000 (sll $0 NOP), including PC ≥ DEPTH, any upper PC bits set, and IDLE/LOAD states.
  - Zero latency: pure combinational from PC and state.
- load_clear (any state):
  - Next state IDLE; wr_ptr, byte_cnt, prog_len and overflow are cleared; core_run drops next cycle.
  - load_clear has priority over a simultaneously accepted byte; that byte is dropped.
- load_last with an empty program (first byte) gives prog_len=1: one padded word.
- Reset mid-load aborts the load; partially written words remain in memory but are unreachable because prog_len=0.

Decomposition:
- Shared package mips_pkg holds:
  - typedef ldr_state_t {IDLE, LOAD, RUN}.
  - localparam NOP_INSTR = 32'h0.
  - The instruction word width.
- One natural sub-module, instr_store: DEPTH×32 single-write-port array with synchronous write and asynchronous read, in the same style as Register_Memory.
- The top level holds the FSM, the byte packer and the bounds check.

Test Plan:
- Reset then stream 8 bytes 20,08,00,05,20,09,00,07 (last on the 8th) → words 32'h2008_0005 at PC=0 and 32'h2009_0007 at PC=1; prog_len=2; core_run=1 the cycle after the last byte; Instr=0 at PC=2.
- Stream 6 bytes AA,BB,CC,DD,11,22 with last on the 6th → PC=1 returns 32'h1122_0000; prog_len=2.
- Stream DEPTH×4+3 bytes with last on the final byte → prog_len=64, overflow=1, core_run=1; mem[63] equals the 64th word; the extra bytes are absent.
- Apply load_valid with random ready-gaps and bubbles (load_valid=0 mid-word) → same packed words as the gap-free case; no byte is accepted while load_ready=0 in RUN.
- In RUN with prog_len=2, assert load_clear together with load_valid → state IDLE, core_run=0, prog_len=0, overflow=0, Instr=0 for PC=0; the coincident byte is not stored.
- Assert reset low asynchronously mid-word (byte_cnt=2) → outputs return to reset values immediately; a subsequent 4-byte load writes to PC=0 correctly.
